// File: rtl/abs_serial_pkg.sv
// Shared types and constants for the bit-serial absolute-value converter.
package abs_serial_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/abs_serial_if.sv
// Request/result bundle between a requester (master) and abs_serial (slave).
interface abs_serial_if #(
   parameter int unsigned WIDTH = abs_serial_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic             sign;
   logic [WIDTH-1:0] mag;
   logic             ovf;

   modport master (output start, din, input busy, done, sign, mag, ovf);
   modport slave  (input start, din, output busy, done, sign, mag, ovf);
endinterface

// File: rtl/serial_neg_cell.sv
// One-bit serial two's-complement negation: pass bits until the first 1, invert afterwards.
module serial_neg_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic in_bit,
   output logic out_bit
);

   logic seen_q, seen_d;

   // seen_q only rises when en is high, so a cell left disabled is a plain pass-through
   assign out_bit = in_bit ^ seen_q;

   always_comb begin
      seen_d = seen_q;
      if (clr) begin
         seen_d = 1'b0;
      end else if (en && in_bit) begin
         seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q <= 1'b0;
      end else begin
         seen_q <= seen_d;
      end
   end

endmodule

// File: rtl/abs_serial.sv
// Bit-serial |din|: LSB-first over WIDTH cycles, one-cycle done pulse, overflow flag for the most-negative input.
module abs_serial
   import abs_serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   abs_serial_if.slave   bus
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
   logic             out_bit;
   logic [WIDTH-1:0] mag_shift;

   serial_neg_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept),
      .en      ((state_q == SHIFT) && sign_q),
      .in_bit  (sreg_q[0]),
      .out_bit (out_bit)
   );

   assign mag_shift = {out_bit, mag_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      mag_d   = mag_q;
      sign_d  = sign_q;
      ovf_d   = ovf_q;
      accept  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = SHIFT;
               sreg_d  = bus.din;
               sign_d  = bus.din[WIDTH-1];
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sreg_d = sreg_q >> 1;
            mag_d  = mag_shift;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // ovf is resolved together with the final bit so it is valid alongside done
               state_d = DONE;
               ovf_d   = sign_q && (mag_shift == {1'b1, {(WIDTH-1){1'b0}}});
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sign = sign_q;
   assign bus.mag  = mag_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: doc/abs_serial.md
ABS_SERIAL -- requirements
Module: abs_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal values 4 to 32).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 is the sole clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to convert din.
REQ-005 The block SHALL have port din, input, WIDTH bits: two's-complement operand.
REQ-006 The block SHALL have port busy, output, 1 bit: conversion in progress, with start ignored while it is high.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-008 The block SHALL have port sign, output, 1 bit: sign (MSB) of the captured operand.
REQ-009 The block SHALL have port mag, output, WIDTH bits: unsigned magnitude |din|.
REQ-010 The block SHALL have port ovf, output, 1 bit: high when the operand equals the most-negative value, so mag does not fit in the signed range.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT and DONE, and SHALL reset to IDLE.
REQ-012 In IDLE or DONE, start=1 SHALL capture din into the shift register, set sign=din[WIDTH-1], clear the bit counter and the seen-one flag, and go to SHIFT.
REQ-013 In SHIFT, the block SHALL process one operand bit per clock, LSB first, for exactly WIDTH cycles, then go to DONE.
REQ-014 For each processed bit, out_bit SHALL equal in_bit when sign=0, or when sign=1 and no 1 has yet been seen; otherwise out_bit SHALL equal ~in_bit.
REQ-015 The seen-one flag SHALL set on the first in_bit=1, after that bit is emitted.
REQ-016 out_bit SHALL be shifted into mag from the MSB side, so that after WIDTH shifts mag[0] holds the result LSB.
REQ-017 busy SHALL be 1 exactly while in SHIFT.
REQ-018 done SHALL be 1 exactly while in DONE, which lasts one cycle.
REQ-019 Latency: with start sampled at edge N, done SHALL be high between edges N+WIDTH and N+WIDTH+1.
REQ-020 If start is 0 in DONE, the FSM SHALL return to IDLE.
REQ-021 start=1 in DONE SHALL begin a new conversion with no idle gap, giving a throughput of one result per WIDTH+1 cycles.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the register, counter, sign or mag.
REQ-023 sign, mag and ovf SHALL hold their last result until the next accepted start.
REQ-024 mag SHALL show intermediate values during SHIFT and be valid only when done=1 or afterwards.
REQ-025 ovf SHALL be set in DONE when sign=1 and mag equals 1 followed by WIDTH-1 zeros; otherwise it SHALL be 0.
REQ-026 din=0 SHALL give sign=0, mag=0 and ovf=0.
REQ-027 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL wrap only via reload on start, never by overflow.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, sign=0, mag=0, ovf=0, counter=0 and the seen-one flag to 0.
REQ-029 Reset asserted mid-SHIFT SHALL abort the conversion with no done pulse; after release, the block SHALL require a new start.
REQ-030 start high in the first edge after rst_n deasserts SHALL be accepted normally.

Structure
REQ-031 The state enum (IDLE, SHIFT, DONE) and the default WIDTH constant SHALL live in shared package abs_serial_pkg.
REQ-032 The per-bit transform and seen-one flag SHALL be a sub-module serial_neg_cell, with ports clk, rst_n, clr, en, in_bit and out_bit.
REQ-033 Parallel outputs SHALL match the existing combinational two's-complement negator for negative inputs; the bench SHALL use that negator as the reference model.

Verification
REQ-034 Scenario: din=8'hBB with start pulsed -> done exactly 8 cycles later, sign=1, mag=8'h45, ovf=0.
REQ-035 Scenario: din=8'h45 -> sign=0, mag=8'h45, ovf=0; din=8'h00 -> sign=0, mag=8'h00.
REQ-036 Scenario: din=8'h80 -> sign=1, mag=8'h80, ovf=1; din=8'hFF -> sign=1, mag=8'h01, ovf=0.
REQ-037 Scenario: start=1 held continuously with din=8'hBB then 8'h45 -> back-to-back done pulses 9 cycles apart; start during busy changes nothing.
REQ-038 Scenario: rst_n pulsed low at SHIFT cycle 4 of din=8'hBB -> all outputs 0 at once, no done; a later start with 8'hF0 -> mag=8'h10.
REQ-039 Scenario: exhaustive sweep of all 256 din values -> mag equals the reference negator output for din[7]=1 and equals din otherwise; ovf is high only for 8'h80.
